// File: rtl/iiitb_pwm_pkg.sv
// rtl/iiitb_pwm_pkg.sv - shared PWM types and duty-cycle constants
package iiitb_pwm_pkg;

  // Divider sequencing: idle, or iterating the restoring divider
  typedef enum logic {
    IDLE = 1'b0,
    DIV  = 1'b1
  } div_state_e;

  // Duty cycle is reported in tenths, same encoding as the generator
  localparam int DUTY_STEPS = 10;
  localparam int DUTY_W     = 4;

endpackage

// File: rtl/iiitb_pwm_sync.sv
// rtl/iiitb_pwm_sync.sv - synchronizer and rising-edge detect for pwm_in
module iiitb_pwm_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_in,
  output logic pwm_s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_d;

  // Shift the async input through the synchronizer chain, keep one delayed copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      pwm_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      pwm_d  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pwm_s = sync_q[SYNC_STAGES-1];
  assign rise  = pwm_s & ~pwm_d;

endmodule

// File: rtl/iiitb_pwm_meas.sv
// rtl/iiitb_pwm_meas.sv - PWM period, high-time and duty-tenths measurement
module iiitb_pwm_meas
  import iiitb_pwm_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 2**CNT_W-1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic [DUTY_W-1:0] duty_tenths,
  output logic              meas_valid,
  output logic              timeout
);

  localparam int                NUM_W   = CNT_W + 4;
  localparam logic [CNT_W-1:0]  TMO_CNT = CNT_W'(TIMEOUT);
  localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(DUTY_STEPS);

  logic              pwm_s;
  logic              rise;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  high_cnt;
  logic              armed;
  div_state_e        state_q;
  div_state_e        state_d;
  logic [CNT_W-1:0]  op_p;
  logic [CNT_W-1:0]  op_h;
  logic [NUM_W-1:0]  rem;
  logic [DUTY_W-2:0] quot_hi;
  logic [1:0]        iter;

  logic              tmo_hit;
  logic              start;
  logic              div_step;
  logic              div_last;
  logic [NUM_W-1:0]  shifted;
  logic              trial_ok;
  logic [DUTY_W-1:0] q_final;
  logic [DUTY_W-1:0] q_clamped;

  iiitb_pwm_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .pwm_in (pwm_in),
    .pwm_s  (pwm_s),
    .rise   (rise)
  );

  // A rise on the threshold cycle wins; timeout reports once until a valid measurement
  assign tmo_hit = (cnt == TMO_CNT) && !rise && !timeout;
  assign start   = rise && armed && (state_q == IDLE);

  // Restoring step: try subtracting P shifted to the current quotient bit
  assign shifted   = NUM_W'(op_p) << iter;
  assign trial_ok  = (rem >= shifted);
  assign q_final   = {quot_hi, trial_ok};
  assign q_clamped = (q_final > DUTY_MAX) ? DUTY_MAX : q_final;

  // Period and high-time counters, restarted by every rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      high_cnt <= '0;
    end else if (rise) begin
      cnt      <= CNT_W'(1);
      high_cnt <= CNT_W'(1);
    end else begin
      if (cnt != TMO_CNT) cnt <= cnt + CNT_W'(1);
      if (pwm_s && (high_cnt != '1)) high_cnt <= high_cnt + CNT_W'(1);
    end
  end

  // First rise after reset or timeout only arms; timeout disarms
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       armed <= 1'b0;
    else if (rise)    armed <= 1'b1;
    else if (tmo_hit) armed <= 1'b0;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: four divide cycles, aborted by timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = DIV;
      DIV:     if (tmo_hit || (iter == 2'd0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: divider step enable and final-iteration strobe
  always_comb begin
    div_step = (state_q == DIV) && !tmo_hit;
    div_last = div_step && (iter == 2'd0);
  end

  // Operand latch and restoring divider datapath, MSB quotient bit first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_p    <= '0;
      op_h    <= '0;
      rem     <= '0;
      quot_hi <= '0;
      iter    <= '0;
    end else if (start) begin
      op_p    <= cnt;
      op_h    <= high_cnt;
      rem     <= NUM_W'(high_cnt) * NUM_W'(DUTY_STEPS);
      quot_hi <= '0;
      iter    <= 2'd3;
    end else if (div_step) begin
      if (trial_ok) rem <= rem - shifted;
      quot_hi <= {quot_hi[DUTY_W-3:0], trial_ok};
      iter    <= iter - 2'd1;
    end
  end

  // Output registers: updated by a finished division or by a timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period      <= '0;
      high_time   <= '0;
      duty_tenths <= '0;
      meas_valid  <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (tmo_hit) begin
        period      <= '0;
        high_time   <= '0;
        duty_tenths <= pwm_s ? DUTY_MAX : '0;
        meas_valid  <= 1'b1;
        timeout     <= 1'b1;
      end else if (div_last) begin
        period      <= op_p;
        high_time   <= op_h;
        duty_tenths <= q_clamped;
        meas_valid  <= 1'b1;
        timeout     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iiitb_pwm_meas.sv
// tb/tb_iiitb_pwm_meas.sv - self-checking bench for iiitb_pwm_meas
module tb_iiitb_pwm_meas;

  localparam int TMO = 64;
  localparam int NEXP = 19;

  typedef struct {
    int p;
    int h;
    int d;
    int t;
  } meas_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pwm_in;
  logic [15:0] period;
  logic [15:0] high_time;
  logic [3:0]  duty_tenths;
  logic        meas_valid;
  logic        timeout;

  int tot = 0;
  int bad = 0;
  bit chk_en = 0;

  // behavioural model state: sample history and event bookkeeping by edge index
  bit    s_hist [int];
  int    n = 0;
  bit    in_reset = 0;
  bit    m_armed = 0;
  int    m_last = 0;
  int    m_origin = 0;
  int    m_busy = 0;
  int    pend_edge = -1;
  int    pend_p, pend_h, pend_d;
  logic [15:0] exp_period = '0;
  logic [15:0] exp_high = '0;
  logic [3:0]  exp_duty = '0;
  logic        exp_valid = 1'b0;
  logic        exp_tmo = 1'b0;

  meas_t dut_q [$];
  meas_t mdl_q [$];

  int tab_p [NEXP] = '{10,10,10, 10,10,10, 7,4,4, 0, 10,10,0, 10, 10,9,10, 10,10};
  int tab_h [NEXP] = '{ 5, 5, 5,  5, 1, 9, 3,2,2, 0,  5, 5,0,  5,  5,5, 5,  5, 5};
  int tab_d [NEXP] = '{ 5, 5, 5,  5, 1, 9, 4,5,5, 0,  5, 5,10, 5,  5,5, 5,  5, 5};
  int tab_t [NEXP] = '{ 0, 0, 0,  0, 0, 0, 0,0,0, 1,  0, 0,1,  0,  0,0, 0,  0, 0};

  iiitb_pwm_meas #(.CNT_W(16), .SYNC_STAGES(2), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwm_in      (pwm_in),
    .period      (period),
    .high_time   (high_time),
    .duty_tenths (duty_tenths),
    .meas_valid  (meas_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  // Model: a rise sampled at edge m is decided at edge m+2; results appear 4 edges later
  always @(posedge clk) begin
    int  m, hsum, d;
    bit  rise_now, tmo_now;
    n = n + 1;
    exp_valid = 1'b0;
    if (!rst_n) begin
      s_hist[n] = 1'b0;
      in_reset  = 1;
      m_armed   = 0;
      m_busy    = 0;
      pend_edge = -1;
      exp_period = '0;
      exp_high   = '0;
      exp_duty   = '0;
      exp_tmo    = 1'b0;
    end else begin
      if (in_reset) begin
        m_origin = n - 2;
        in_reset = 0;
      end
      s_hist[n] = pwm_in;
      m = n - 2;
      rise_now = s_hist[m] && !s_hist[m-1];
      tmo_now  = !rise_now && (n == m_origin + TMO + 2) && !exp_tmo;
      if (pend_edge == n && !tmo_now) begin
        exp_period = 16'(pend_p);
        exp_high   = 16'(pend_h);
        exp_duty   = 4'(pend_d);
        exp_tmo    = 1'b0;
        exp_valid  = 1'b1;
      end
      if (rise_now) begin
        if (m_armed && n >= m_busy) begin
          hsum = 0;
          for (int i = m_last; i < m; i++) hsum += int'(s_hist[i]);
          d = (10 * hsum) / (m - m_last);
          if (d > 10) d = 10;
          pend_p = m - m_last;
          pend_h = hsum;
          pend_d = d;
          pend_edge = n + 4;
          m_busy = n + 5;
        end
        m_armed  = 1;
        m_last   = m;
        m_origin = m;
      end else if (tmo_now) begin
        exp_period = '0;
        exp_high   = '0;
        exp_duty   = s_hist[n-2] ? 4'd10 : 4'd0;
        exp_tmo    = 1'b1;
        exp_valid  = 1'b1;
        m_armed    = 0;
        m_busy     = 0;
        pend_edge  = -1;
      end
      if (exp_valid)
        mdl_q.push_back('{int'(exp_period), int'(exp_high), int'(exp_duty), int'(exp_tmo)});
    end
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    logic [15:0] wp, wh;
    logic [3:0]  wd;
    logic        wv, wt;
    if (chk_en) begin
      if (!rst_n) begin
        {wp, wh, wd, wv, wt} = '0;
      end else begin
        wp = exp_period; wh = exp_high; wd = exp_duty; wv = exp_valid; wt = exp_tmo;
      end
      tot++;
      if (period !== wp || high_time !== wh || duty_tenths !== wd ||
          meas_valid !== wv || timeout !== wt) begin
        bad++;
        $display("FAIL cycle_cmp t=%0t got p=%0d h=%0d d=%0d v=%b to=%b want p=%0d h=%0d d=%0d v=%b to=%b",
                 $time, period, high_time, duty_tenths, meas_valid, timeout, wp, wh, wd, wv, wt);
      end
      if (rst_n && meas_valid === 1'b1)
        dut_q.push_back('{int'(period), int'(high_time), int'(duty_tenths), int'(timeout)});
    end
  end

  task automatic hold(input bit v, input int cyc);
    pwm_in = v;
    repeat (cyc) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic pulse(input int p, input int h);
    hold(1'b1, h);
    hold(1'b0, p - h);
  endtask

  task automatic check_zero(input string name);
    tot++;
    if (period !== '0 || high_time !== '0 || duty_tenths !== '0 || meas_valid !== 1'b0 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL %s got p=%0d h=%0d d=%0d v=%b to=%b want all zero",
               name, period, high_time, duty_tenths, meas_valid, timeout);
    end
  endtask

  task automatic check_log(input string name, input meas_t q [$]);
    tot++;
    if (q.size() != NEXP) begin
      bad++;
      $display("FAIL %s_count got %0d want %0d", name, q.size(), NEXP);
    end
    for (int i = 0; i < NEXP; i++) begin
      if (i < q.size()) begin
        tot++;
        if (q[i].p != tab_p[i] || q[i].h != tab_h[i] || q[i].d != tab_d[i] || q[i].t != tab_t[i]) begin
          bad++;
          $display("FAIL %s[%0d] got p=%0d h=%0d d=%0d to=%0d want p=%0d h=%0d d=%0d to=%0d",
                   name, i, q[i].p, q[i].h, q[i].d, q[i].t, tab_p[i], tab_h[i], tab_d[i], tab_t[i]);
        end
      end
    end
  endtask

  initial begin
    rst_n  = 1'b1;
    pwm_in = 1'b0;
    #1 rst_n = 1'b0;
    chk_en = 1;
    @(posedge clk);
    #3;
    hold(1'b0, 3);
    rst_n = 1'b1;
    #1 check_zero("reset_state");
    #2;
    hold(1'b0, 4);

    // generator pattern: first rise arms, then one result per period
    repeat (4) pulse(10, 5);
    // duty 1, 9 and floor(30/7)
    pulse(10, 1);
    pulse(10, 9);
    pulse(7, 3);
    // period below the reporting minimum: alternate rises only
    repeat (6) pulse(4, 2);
    // stuck low
    hold(1'b0, 70);
    // re-arm, measure, then stuck high
    pulse(10, 5);
    pulse(10, 5);
    hold(1'b1, 80);
    hold(1'b0, 5);
    pulse(10, 5);
    pulse(10, 5);

    // transition 1 ns before an edge, then 1 ns after one
    #6 pwm_in = 1'b1;
    @(posedge clk); #3;
    hold(1'b1, 4);
    hold(1'b0, 4);
    #6 pwm_in = 1'b1;
    @(posedge clk); #3;
    hold(1'b1, 4);
    hold(1'b0, 4);
    @(posedge clk);
    #1 pwm_in = 1'b1;
    #2;
    hold(1'b1, 5);
    hold(1'b0, 5);

    // reset two cycles into a division
    pwm_in = 1'b1;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_zero("reset_mid_div");
    pwm_in = 1'b0;
    #2;
    hold(1'b0, 3);
    rst_n = 1'b1;
    hold(1'b0, 4);
    pulse(10, 5);
    pulse(10, 5);
    hold(1'b1, 2);
    hold(1'b0, 10);

    chk_en = 0;
    check_log("dut_log", dut_q);
    check_log("model_log", mdl_q);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
